bram_host_driver: RTL
=====================

// Module: bram_host_driver
// PURPOSE
//  Host-side initiator for the compute-RAM system's external BRAM port and start/done handshake.
//  - Loads a stream of input words into BRAM, then raises start and waits for done.
//  - Reads the result words back and streams them out with valid/ready backpressure.
//  - Sits between a testbench/host stream and the system top; drives external, bram_*_ext and start.
// PARAMETERS
//  BRAM_DWIDTH    40     BRAM word width
//  BRAM_AWIDTH    9      BRAM address width; addresses wrap modulo 2**BRAM_AWIDTH
//  TIMEOUT_CYCLES 1024   max cycles in WAIT_DONE before timeout error; 0 disables the timeout
// PORTS
//  clk             in   1     single clock
//  reset           in   1     synchronous, active-high
//  go              in   1     pulse; latches cfg_* and starts a job (sampled in IDLE only)
//  cfg_in_base     in   AW    first BRAM address for input words
//  cfg_in_count    in   AW+1  number of input words (0..2**AW)
//  cfg_out_base    in   AW    first BRAM address for result words
//  cfg_out_count   in   AW+1  number of result words to read back
//  s_valid/s_data  in   1/DW  input word stream
//  s_ready         out  1     input word accepted when s_valid & s_ready
//  m_valid/m_data  out  1/DW  result word stream
//  m_ready         in   1     downstream accept
//  external        out  1     1 = host owns BRAM port a
//  bram_addr_ext   out  AW    BRAM port-a address
//  bram_wdata_ext  out  DW    BRAM port-a write data
//  bram_wren_ext   out  1     BRAM port-a write enable
//  bram_rdata_ext  in   DW    BRAM port-a read data, valid 1 cycle after address with wren=0
//  start           out  1     level; held high from RUN until done is seen
//  done            in   1     one-cycle pulse from the system
//  busy            out  1     high in every state except IDLE
//  job_done        out  1     one-cycle pulse when the last result is accepted
//  err_timeout     out  1     sticky; cleared by reset or the next accepted go
// BEHAVIOUR
//  - Reset values: state=IDLE; all outputs 0 except external=1, which keeps the port safe.
//  - A reset mid-job aborts immediately. Buffered data is dropped.
//  - FSM states: IDLE, LOAD, RUN, WAIT_DONE, UNLOAD, FINISH.
//  - IDLE: go=1 latches cfg_* and clears err_timeout.
//    - Next state is LOAD; LOAD is skipped when cfg_in_count==0.
//    - go outside IDLE is ignored.
//  - LOAD:
//    - external=1, s_ready=1.
//    - Each handshake writes s_data to in_base+idx in the same cycle: bram_wren_ext=1, combinational from s_valid&s_ready.
//    - After the accept with idx==in_count-1, go to RUN. No writes occur without a handshake.
//  - RUN: external=0, start=1, then go to WAIT_DONE next cycle.
//  - WAIT_DONE:
//    - start stays high; done=1 sets start=0 and goes to UNLOAD.
//    - done in the same cycle as the timeout limit counts as done.
//    - Timeout: after TIMEOUT_CYCLES cycles without done, set err_timeout, set start=0, go to FINISH, skipping UNLOAD.
//  - UNLOAD:
//    - external=1, bram_wren_ext=0, one read per cycle at out_base+rd_idx.
//    - A read is issued only when outstanding reads plus skid occupancy is below 2.
//    - Read data is captured into the skid buffer exactly 1 cycle after issue.
//    - With m_ready held high, throughput is 1 word/cycle.
//    - m_valid/m_data stay stable until accepted.
//    - After the last accept, go to FINISH. cfg_out_count==0 goes straight to FINISH.
//  - FINISH: job_done=1 for one cycle, then IDLE.
//  - Address arithmetic is base+idx truncated to AW bits (0x1FF+1 -> 0x000).
//  - Counters are AW+1 bits so that count 2**AW is legal.
// CONFIGURATION
//  - Macro: BRAM_HOST_DRIVER_CHECKSUM_EN.
//  - Defined:
//    - Extra output port checksum[DW-1:0], reset 0 and cleared on accepted go.
//    - It is the XOR of every m_data accepted in the job.
//    - It is stable from the job_done pulse until the next go.
//  - Undefined: no checksum port or logic exists.
// STRUCTURE
//  - Shared package bram_host_pkg:
//    - State enum (IDLE..FINISH).
//    - BRAM_DWIDTH and BRAM_AWIDTH defaults.
//    - A bram_addr_t typedef.
//  - One sub-module, bram_host_skid: 2-entry valid/ready buffer.
//    - Has push, push_data, full-or-reserved count, and m_* outputs.
//  - FSM, counters and address generation stay in the top module.
// TESTING
//  1. Reset held 3 cycles mid-LOAD -> all outputs 0, external=1; state IDLE, no further writes.
//  2. in_base=0x1FE, count=4, s_valid always 1 -> writes to 0x1FE, 0x1FF, 0x000, 0x001; s_ready drops after 4.
//  3. in_count=2, done pulse 5 cycles after start -> start high exactly from RUN until the done cycle, then low.
//  4. out_count=3 with m_ready toggling 1,0,0,1,... -> m_data order matches BRAM; no loss or duplication.
//  5. TIMEOUT_CYCLES=8, done never asserted -> err_timeout=1, start=0; job_done pulses; no reads issued.
//  6. CHECKSUM_EN, results 0x1, 0x3, 0x4 -> checksum 0x6 at job_done; go clears it to 0.

Source files
------------

// File: rtl/bram_host_pkg.sv
// Shared types for the BRAM host driver: FSM state encoding, default
// BRAM geometry and the BRAM address type.
package bram_host_pkg;

  localparam int BRAM_DWIDTH = 40;
  localparam int BRAM_AWIDTH = 9;

  typedef logic [BRAM_AWIDTH-1:0] bram_addr_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_RUN       = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_UNLOAD    = 3'd4,
    ST_FINISH    = 3'd5
  } state_t;

endpackage

// File: rtl/bram_host_skid.sv
// Two-entry FIFO that catches BRAM read data one cycle after each read is
// issued and presents it on a valid/ready stream. The owner must never push
// while two entries are already held; count reports current occupancy so the
// owner can reserve room for reads still in flight.
module bram_host_skid
  import bram_host_pkg::*;
#(
  parameter int DW = BRAM_DWIDTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  output logic [1:0]    count,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  input  logic          m_ready
);

  logic [DW-1:0] mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic          pop;

  assign pop     = m_valid & m_ready;
  assign m_valid = (count != 2'd0);
  // Head entry is held until accepted; zero when empty so nothing stale leaks.
  assign m_data  = m_valid ? mem[rd_ptr] : '0;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are qualified by count so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/bram_host_driver.sv
// Host-side initiator for the compute-RAM system: loads input words into
// BRAM over port a, pulses the start/done handshake, then streams results
// back out. Optional XOR checksum of accepted results is built when
// BRAM_HOST_DRIVER_CHECKSUM_EN is defined.
//
// Stream handshakes (s_* and m_*): a word transfers on a cycle where valid
// and ready are both high; a producer holding valid high keeps data stable
// until that transfer, and valid never depends on ready.
module bram_host_driver
  import bram_host_pkg::*;
#(
  parameter int BRAM_DWIDTH    = bram_host_pkg::BRAM_DWIDTH,
  parameter int BRAM_AWIDTH    = bram_host_pkg::BRAM_AWIDTH,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   go,
  input  logic [BRAM_AWIDTH-1:0] cfg_in_base,
  input  logic [BRAM_AWIDTH:0]   cfg_in_count,
  input  logic [BRAM_AWIDTH-1:0] cfg_out_base,
  input  logic [BRAM_AWIDTH:0]   cfg_out_count,
  input  logic                   s_valid,
  input  logic [BRAM_DWIDTH-1:0] s_data,
  output logic                   s_ready,
  output logic                   m_valid,
  output logic [BRAM_DWIDTH-1:0] m_data,
  input  logic                   m_ready,
  output logic                   external,
  output logic [BRAM_AWIDTH-1:0] bram_addr_ext,
  output logic [BRAM_DWIDTH-1:0] bram_wdata_ext,
  output logic                   bram_wren_ext,
  input  logic [BRAM_DWIDTH-1:0] bram_rdata_ext,
  output logic                   start,
  input  logic                   done,
  output logic                   busy,
  output logic                   job_done,
  output logic                   err_timeout,
`ifdef BRAM_HOST_DRIVER_CHECKSUM_EN
  output logic [BRAM_DWIDTH-1:0] checksum,
`endif
  output state_t                 fsm_state
);

  localparam int CW = BRAM_AWIDTH + 1;

  state_t                 state;
  state_t                 state_next;

  logic [BRAM_AWIDTH-1:0] in_base_q;
  logic [CW-1:0]          in_count_q;
  logic [BRAM_AWIDTH-1:0] out_base_q;
  logic [CW-1:0]          out_count_q;

  logic [CW-1:0]          ld_idx;   // words written so far
  logic [CW-1:0]          rd_idx;   // reads issued so far
  logic [CW-1:0]          acc_idx;  // results accepted downstream so far
  logic                   rd_pend;  // a read was issued last cycle
  logic [31:0]            timer;

  logic [1:0]             skid_count;
  logic [1:0]             inflight;
  logic                   hs_in;
  logic                   last_in;
  logic                   pop;
  logic                   last_out;
  logic                   issue;
  logic                   timeout_hit;

  assign fsm_state = state;

  assign hs_in    = (state == ST_LOAD) && s_valid;
  assign last_in  = hs_in && (ld_idx == in_count_q - CW'(1));
  assign pop      = m_valid & m_ready;
  assign last_out = pop && (acc_idx == out_count_q - CW'(1));

  // Reads in flight plus buffered words, after this cycle's accept frees a slot.
  assign inflight = 2'(rd_pend) + skid_count - 2'(pop);
  assign issue    = (state == ST_UNLOAD) && (rd_idx != out_count_q) && (inflight < 2'd2);

  // A zero limit means the system may take as long as it likes.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (timer == 32'(TIMEOUT_CYCLES - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state and port-a / handshake outputs.
  always_comb begin
    state_next     = state;
    external       = 1'b1;
    s_ready        = 1'b0;
    bram_wren_ext  = 1'b0;
    bram_addr_ext  = '0;
    bram_wdata_ext = '0;
    start          = 1'b0;
    busy           = (state != ST_IDLE);
    job_done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (go) state_next = (cfg_in_count == '0) ? ST_RUN : ST_LOAD;
      end
      ST_LOAD: begin
        s_ready        = 1'b1;
        bram_wren_ext  = s_valid;
        bram_addr_ext  = in_base_q + ld_idx[BRAM_AWIDTH-1:0];
        bram_wdata_ext = s_data;
        if (last_in) state_next = ST_RUN;
      end
      ST_RUN: begin
        external   = 1'b0;
        start      = 1'b1;
        state_next = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        external = 1'b0;
        start    = 1'b1;
        // done wins over a timeout landing in the same cycle
        if (done)             state_next = (out_count_q == '0) ? ST_FINISH : ST_UNLOAD;
        else if (timeout_hit) state_next = ST_FINISH;
      end
      ST_UNLOAD: begin
        bram_addr_ext = out_base_q + rd_idx[BRAM_AWIDTH-1:0];
        if (last_out) state_next = ST_FINISH;
      end
      ST_FINISH: begin
        job_done   = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Job configuration latch and transfer counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_base_q   <= '0;
      in_count_q  <= '0;
      out_base_q  <= '0;
      out_count_q <= '0;
      ld_idx      <= '0;
      rd_idx      <= '0;
      acc_idx     <= '0;
      rd_pend     <= 1'b0;
    end else begin
      rd_pend <= issue;
      if (state == ST_IDLE && go) begin
        in_base_q   <= cfg_in_base;
        in_count_q  <= cfg_in_count;
        out_base_q  <= cfg_out_base;
        out_count_q <= cfg_out_count;
        ld_idx      <= '0;
        rd_idx      <= '0;
        acc_idx     <= '0;
      end
      if (hs_in) ld_idx  <= ld_idx + CW'(1);
      if (issue) rd_idx  <= rd_idx + CW'(1);
      if (pop)   acc_idx <= acc_idx + CW'(1);
    end
  end

  // Cycles spent waiting for done; restarts on every entry to WAIT_DONE.
  always_ff @(posedge clk) begin
    if (reset || state != ST_WAIT_DONE) timer <= '0;
    else                                timer <= timer + 32'd1;
  end

  // Sticky timeout flag, cleared only by reset or the next accepted go.
  always_ff @(posedge clk) begin
    if (reset)                                             err_timeout <= 1'b0;
    else if (state == ST_IDLE && go)                       err_timeout <= 1'b0;
    else if (state == ST_WAIT_DONE && !done && timeout_hit) err_timeout <= 1'b1;
  end

  bram_host_skid #(.DW(BRAM_DWIDTH)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .push      (rd_pend),
    .push_data (bram_rdata_ext),
    .count     (skid_count),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_ready   (m_ready)
  );

`ifdef BRAM_HOST_DRIVER_CHECKSUM_EN
  // XOR of every result accepted in the current job.
  always_ff @(posedge clk) begin
    if (reset)                       checksum <= '0;
    else if (state == ST_IDLE && go) checksum <= '0;
    else if (pop)                    checksum <= checksum ^ m_data;
  end
`endif

endmodule
